// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - load/store sequencer for a single-ported word RAM, splits word-crossing accesses
// Optional build macro MISALIGN_TRAP_EN: word-crossing accesses complete with resp_err instead of being split.
module mem_access_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_wbe,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  localparam logic [ADDR_WIDTH-3:0] WORD_ONE = 1;

  state_t                  state_q, state_d;
  logic                    store_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    err_q;
  logic [31:0]             lo_q;

  function automatic logic illegal_f(input logic st, input logic [2:0] f3);
    illegal_f = st ? (f3 >= 3'd3) : ((f3 == 3'd3) || (f3[2:1] == 2'b11));
  endfunction

  function automatic logic split_f(input logic [2:0] f3, input logic [1:0] off);
    split_f = ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
              ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  logic                  req_bad;
  logic                  split_q;
  logic [1:0]            off;
  logic [ADDR_WIDTH-3:0] wa;
  logic [7:0]            be_base;
  logic [7:0]            be64;
  logic [63:0]           wd64;
  logic [31:0]           lo_eff, hi_eff, v;
  logic [31:0]           ext;

`ifdef MISALIGN_TRAP_EN
  assign req_bad = illegal_f(req_store, req_funct3) || split_f(req_funct3, req_addr[1:0]);
`else
  assign req_bad = illegal_f(req_store, req_funct3);
`endif

  assign off     = addr_q[1:0];
  assign wa      = addr_q[ADDR_WIDTH-1:2];
  assign split_q = split_f(funct3_q, off);

  assign be_base = (funct3_q[1:0] == 2'b00) ? 8'h01 :
                   (funct3_q[1:0] == 2'b01) ? 8'h03 : 8'h0F;
  assign be64    = be_base << off;
  assign wd64    = {32'b0, wdata_q} << {off, 3'b000};

  // In DONE, mem_rdata carries the last word read: the only word when unsplit, the upper one when split.
  assign lo_eff = split_q ? lo_q : mem_rdata;
  assign hi_eff = split_q ? mem_rdata : 32'h0;
  assign v      = 32'({hi_eff, lo_eff} >> {off, 3'b000});

  always_comb begin
    case (funct3_q)
      3'd0:    ext = {{24{v[7]}}, v[7:0]};
      3'd1:    ext = {{16{v[15]}}, v[15:0]};
      3'd4:    ext = {24'b0, v[7:0]};
      3'd5:    ext = {16'b0, v[15:0]};
      default: ext = v;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      lo_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req_valid) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_bad;
      end
`ifndef MISALIGN_TRAP_EN
      if (state_q == ACC1) lo_q <= mem_rdata;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_bad ? DONE : ACC0;
`ifdef MISALIGN_TRAP_EN
      ACC0: state_d = DONE;
`else
      ACC0: state_d = split_q ? ACC1 : DONE;
      ACC1: state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wbe    = 4'b0;
    mem_wdata  = 32'h0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        mem_en    = 1'b1;
        mem_addr  = wa;
        mem_wbe   = store_q ? be64[3:0] : 4'b0;
        mem_wdata = wd64[31:0];
      end
`ifndef MISALIGN_TRAP_EN
      ACC1: begin
        mem_en    = 1'b1;
        mem_addr  = wa + WORD_ONE;
        mem_wbe   = store_q ? be64[7:4] : 4'b0;
        mem_wdata = wd64[63:32];
      end
`endif
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? 32'h0 : ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer with a byte-enabled RAM model
module tb_mem_access_sequencer;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    time         t_issue;
    int          lat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  acc_t  acc_q[$];
  resp_t exp_q[$];

  logic [31:0] ram [256];
  logic        bd_en = 1'b0;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wbe(mem_wbe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (bd_en) ram[bd_idx] <= bd_data;
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        chk("ready_low_when_busy", {31'b0, req_ready}, 32'h0);
        if (acc_q.size() == 0) begin
          chk("unexpected_mem_en", 32'h1, 32'h0);
        end else begin
          acc_t a;
          logic [31:0] m;
          a = acc_q.pop_front();
          m = {{8{a.wbe[3]}}, {8{a.wbe[2]}}, {8{a.wbe[1]}}, {8{a.wbe[0]}}};
          chk("mem_addr", {2'b0, mem_addr}, {2'b0, a.addr});
          chk("mem_wbe", {28'b0, mem_wbe}, {28'b0, a.wbe});
          chk("mem_wdata", mem_wdata & m, a.wdata & m);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
          chk("latency", 32'(($time - r.t_issue) / 10), 32'(r.lat));
        end
      end
    end
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input bit ee,
                       input int lat, input bit split, input int n, input acc_t a0, input acc_t a1);
    resp_t r;
    int    w;
    if (split && TRAP) begin
      er = 32'h0; ee = 1'b1; lat = 1; n = 0;
    end
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 32'h1, 32'h0);
    if (n > 0) acc_q.push_back(a0);
    if (n > 1) acc_q.push_back(a1);
    r.rdata = er; r.err = ee; r.t_issue = $time; r.lat = lat;
    exp_q.push_back(r);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      chk("resp_timeout", 32'h1, 32'h0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  function automatic acc_t A(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d);
    A = '{addr: a, wbe: b, wdata: d};
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; bd_idx = 8'h0; bd_data = 32'h0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    chk("rst_mem_wbe", {28'b0, mem_wbe}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 256; i++) poke(8'(i), 32'h0);
    @(negedge clk); #2 rst = 1'b0;

    poke(8'h40, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));
    poke(8'h40, 32'h80FF7F01);
    issue(0, 3'd0, 32'h103, 0, 32'hFFFFFF80, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));
    issue(0, 3'd4, 32'h103, 0, 32'h00000080, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));
    issue(0, 3'd1, 32'h102, 0, 32'hFFFF80FF, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));
    issue(0, 3'd5, 32'h101, 0, 32'h0000FF7F, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));

    poke(8'h40, 32'h44332211);
    poke(8'h41, 32'h88776655);
    issue(0, 3'd2, 32'h102, 0, 32'h66554433, 0, 3, 1, 2, A(30'h40, 4'h0, 0), A(30'h41, 4'h0, 0));

    issue(1, 3'd1, 32'h107, 32'h0000ABCD, 0, 0, 3, 1, 2,
          A(30'h41, 4'b1000, 32'hCD000000), A(30'h42, 4'b0001, 32'h000000AB));
    if (!TRAP) begin
      issue(0, 3'd1, 32'h107, 0, 32'hFFFFABCD, 0, 3, 1, 2, A(30'h41, 4'h0, 0), A(30'h42, 4'h0, 0));
      issue(0, 3'd5, 32'h107, 0, 32'h0000ABCD, 0, 3, 1, 2, A(30'h41, 4'h0, 0), A(30'h42, 4'h0, 0));
    end

    issue(1, 3'd2, 32'hFFFFFFFE, 32'h11223344, 0, 0, 3, 1, 2,
          A(30'h3FFFFFFF, 4'b1100, 32'h33440000), A(30'h0, 4'b0011, 32'h00001122));
    if (!TRAP)
      issue(0, 3'd2, 32'hFFFFFFFE, 0, 32'h11223344, 0, 3, 1, 2,
            A(30'h3FFFFFFF, 4'h0, 0), A(30'h0, 4'h0, 0));

    issue(1, 3'd0, 32'h101, 32'h123456A5, 0, 0, 2, 0, 1, A(30'h40, 4'b0010, 32'h3456A500), A(0, 0, 0));
    issue(0, 3'd3, 32'h100, 0, 0, 1, 1, 0, 0, A(0, 0, 0), A(0, 0, 0));
    issue(1, 3'd3, 32'h100, 32'hFFFFFFFF, 0, 1, 1, 0, 0, A(0, 0, 0), A(0, 0, 0));
    issue(0, 3'd6, 32'h100, 0, 0, 1, 1, 0, 0, A(0, 0, 0), A(0, 0, 0));
    issue(0, 3'd2, 32'h100, 0, 32'h4433A511, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));

`ifndef MISALIGN_TRAP_EN
    @(negedge clk);
    acc_q.push_back(A(30'h40, 4'h0, 0));
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h102; req_wdata = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk); #3 rst = 1'b0;
    issue(0, 3'd2, 32'h100, 0, 32'h4433A511, 0, 2, 0, 1, A(30'h40, 4'h0, 0), A(0, 0, 0));
`endif

    repeat (3) @(negedge clk);
    chk("acc_q_drained", 32'(acc_q.size()), 32'h0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
